// File: rtl/game_step_ctrl.sv
// game_step_ctrl
// Memory-mapped game sequencer. It turns decoded button events into a paced
// game-step schedule. It owns the run/pause/over state machine, the heading,
// the speed level and the step period. It emits one step pulse per game tick
// and raises its own interrupt.
//
// Parameters
//   BASE_PERIOD  step period in clocks after restart
//   PERIOD_STEP  period decrement per accepted speed-up
//   MIN_PERIOD   period floor (>= 2)
//
// Ports
//   clk, rst                     system clock, async active-high reset
//   wr_addr/wr_en/wr_data/wr_strb register write port (full-word writes only)
//   rd_addr/rd_en/rd_data        combinational register read port
//   turn_left, turn_right        single-cycle turn requests
//   speedup_req, restart_req     single-cycle speed-up / game-reset requests
//   error_in                     single-cycle game-over event
//   step_pulse                   one-cycle pulse per game step
//   heading                      0 up, 1 right, 2 down, 3 left
//   game_state                   0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   irq                          |(IER & IFR)
//
// Register map (wr_addr[3:2] / rd_addr[3:2])
//   0x00 CMD    W1 pulses: [0] START [1] PAUSE [2] RESUME [3] RESTART, reads 0
//   0x04 STATUS [1:0] state [3:2] heading [7:4] level [31:16] step_cnt
//   0x08 IER    [1:0]
//   0x0C IFR    W1C, [0] STEP [1] OVER
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; counters at their restart values
// RUN   | cnt counts down; a tick fires when cnt reaches 0
// PAUSE | cnt held; turns and speed-ups still accepted
// OVER  | game ended by error_in; only RESTART leaves this state

module game_step_ctrl #(
    parameter int BASE_PERIOD = 10000000,
    parameter int PERIOD_STEP = 1000000,
    parameter int MIN_PERIOD  = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [3:0]  rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        turn_left,
    input  logic        turn_right,
    input  logic        speedup_req,
    input  logic        restart_req,
    input  logic        error_in,
    output logic        step_pulse,
    output logic [1:0]  heading,
    output logic [1:0]  game_state,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [23:0] BASE_P = 24'(BASE_PERIOD);
    localparam logic [23:0] STEP_P = 24'(PERIOD_STEP);
    localparam logic [23:0] MIN_P  = 24'(MIN_PERIOD);

    state_t      state_q;
    state_t      state_d;
    logic [23:0] cnt_q;
    logic [23:0] period_q;
    logic [23:0] period_dec;
    logic [3:0]  level_q;
    logic [15:0] step_cnt_q;
    logic [1:0]  heading_q;
    logic [1:0]  heading_turned;
    logic        pend_valid_q;
    logic        pend_right_q;
    logic        step_pulse_q;
    logic [1:0]  ier_q;
    logic [1:0]  ifr_q;
    logic [1:0]  ifr_clr;

    logic        wr_ok;
    logic        cmd_wr;
    logic        ier_wr;
    logic        ifr_wr;
    logic        cmd_start;
    logic        cmd_pause;
    logic        cmd_resume;
    logic        restart;
    logic        active;
    logic        err_ok;
    logic        start_go;
    logic        tick;
    logic        turn_ok;
    logic        speed_ok;

    logic        unused_bits;
    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:4]};

    // ---------------------------------------------------------------
    // Write decode
    // ---------------------------------------------------------------
    assign wr_ok      = wr_en && (wr_strb == 4'b1111);
    assign cmd_wr     = wr_ok && (wr_addr[3:2] == 2'd0);
    assign ier_wr     = wr_ok && (wr_addr[3:2] == 2'd2);
    assign ifr_wr     = wr_ok && (wr_addr[3:2] == 2'd3);

    assign cmd_start  = cmd_wr && wr_data[0];
    assign cmd_pause  = cmd_wr && wr_data[1];
    assign cmd_resume = cmd_wr && wr_data[2];
    assign restart    = (cmd_wr && wr_data[3]) || restart_req;

    // ---------------------------------------------------------------
    // Event qualification; RESTART > error_in > CMD
    // ---------------------------------------------------------------
    assign active   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign err_ok   = error_in && active && !restart;
    assign start_go = (state_q == ST_IDLE) && cmd_start && !restart;
    assign tick     = (state_q == ST_RUN) && (cnt_q == 24'd0) && !restart && !error_in;
    assign turn_ok  = active && (turn_left ^ turn_right) && !restart;
    assign speed_ok = active && speedup_req && !restart;

    // Period is never below MIN_P, so the subtraction cannot underflow.
    always_comb begin
        period_dec = MIN_P;
        if ((period_q - MIN_P) > STEP_P) begin
            period_dec = period_q - STEP_P;
        end
    end

    always_comb begin
        heading_turned = heading_q;
        if (pend_valid_q) begin
            heading_turned = pend_right_q ? 2'(heading_q + 2'd1) : 2'(heading_q - 2'd1);
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_IDLE;
        end else if (err_ok) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_IDLE:  if (cmd_start)  state_d = ST_RUN;
                ST_RUN:   if (cmd_pause)  state_d = ST_PAUSE;
                ST_PAUSE: if (cmd_resume) state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Game datapath: timer, heading, level, period, step counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            period_q     <= BASE_P;
            level_q      <= '0;
            step_cnt_q   <= '0;
            heading_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_right_q <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= tick;
            if (restart) begin
                cnt_q        <= '0;
                period_q     <= BASE_P;
                level_q      <= '0;
                step_cnt_q   <= '0;
                heading_q    <= '0;
                pend_valid_q <= 1'b0;
                pend_right_q <= 1'b0;
            end else begin
                // The reload uses the period as it stood before any
                // speed-up in this same cycle.
                if (start_go || tick) begin
                    cnt_q <= period_q - 24'd1;
                end else if ((state_q == ST_RUN) && !err_ok) begin
                    cnt_q <= cnt_q - 24'd1;
                end

                if (tick) begin
                    step_cnt_q <= step_cnt_q + 16'd1;
                    heading_q  <= heading_turned;
                end

                // On a tick the slot is consumed and refilled by any
                // request arriving in that same cycle.
                if (tick || !pend_valid_q) begin
                    pend_valid_q <= turn_ok;
                    pend_right_q <= turn_right;
                end

                if (speed_ok) begin
                    period_q <= period_dec;
                    if ((period_dec != period_q) && (level_q != 4'hF)) begin
                        level_q <= level_q + 4'd1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Interrupt registers; a set wins over a W1C clear
    // ---------------------------------------------------------------
    assign ifr_clr = ifr_wr ? wr_data[1:0] : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier_q <= '0;
            ifr_q <= '0;
        end else begin
            if (ier_wr) begin
                ier_q <= wr_data[1:0];
            end
            ifr_q <= (ifr_q & ~ifr_clr) | {err_ok, tick};
        end
    end

    // ---------------------------------------------------------------
    // Read mux and outputs
    // ---------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (rd_addr[3:2])
                2'd1:    rd_data = {step_cnt_q, 8'h00, level_q, heading_q, state_q};
                2'd2:    rd_data = {30'd0, ier_q};
                2'd3:    rd_data = {30'd0, ifr_q};
                default: rd_data = '0;
            endcase
        end
    end

    assign step_pulse = step_pulse_q;
    assign heading    = heading_q;
    assign game_state = state_q;
    assign irq        = |(ier_q & ifr_q);

endmodule

// File: tb/tb_game_step_ctrl.sv
module tb_game_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        turn_left;
    logic        turn_right;
    logic        speedup_req;
    logic        restart_req;
    logic        error_in;
    logic        step_pulse;
    logic [1:0]  heading;
    logic [1:0]  game_state;
    logic        irq;

    game_step_ctrl #(
        .BASE_PERIOD(10),
        .PERIOD_STEP(3),
        .MIN_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .turn_left(turn_left),
        .turn_right(turn_right),
        .speedup_req(speedup_req),
        .restart_req(restart_req),
        .error_in(error_in),
        .step_pulse(step_pulse),
        .heading(heading),
        .game_state(game_state),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    string       sb_name[$];
    logic [31:0] sb_exp[$];

    typedef struct {
        bit          do_wr;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  strb;
        bit          re;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic push(input string n, input logic [31:0] e);
        sb_name.push_back(n);
        sb_exp.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] act);
        string       n;
        logic [31:0] e;
        n_vec++;
        if (sb_name.size() == 0) begin
            n_miss++;
            $display("FAIL sb_underflow: got %h with nothing expected", act);
        end else begin
            n = sb_name.pop_front();
            e = sb_exp.pop_front();
            if (act !== e) begin
                n_miss++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = 4'hF;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        #1;
        d       = rd_data;
        rd_en   = 1'b0;
    endtask

    // Cycles until the next step_pulse, bounded; a timeout returns 40.
    task automatic measure(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!step_pulse && n < 40);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: turn_left   = 1'b1;
            1: turn_right  = 1'b1;
            2: speedup_req = 1'b1;
            3: restart_req = 1'b1;
            default: error_in = 1'b1;
        endcase
        step();
        turn_left = 1'b0; turn_right = 1'b0; speedup_req = 1'b0;
        restart_req = 1'b0; error_in = 1'b0;
    endtask

    logic [31:0] r;
    int          n;

    initial begin
        rst = 1'b1;
        wr_addr = '0; wr_en = 1'b0; wr_data = '0; wr_strb = '0;
        rd_addr = '0; rd_en = 1'b0;
        turn_left = 1'b0; turn_right = 1'b0; speedup_req = 1'b0;
        restart_req = 1'b0; error_in = 1'b0;

        vt[0]  = '{1'b1, 4'h8, 32'h3,        4'hF, 1'b1, 4'h8, 32'h3};
        vt[1]  = '{1'b1, 4'h8, 32'h0,        4'h7, 1'b1, 4'h8, 32'h3};
        vt[2]  = '{1'b1, 4'h8, 32'hFFFFFFFC, 4'hF, 1'b1, 4'h8, 32'h0};
        vt[3]  = '{1'b1, 4'h8, 32'h1,        4'h1, 1'b1, 4'h8, 32'h0};
        vt[4]  = '{1'b1, 4'h0, 32'h4,        4'hF, 1'b1, 4'h4, 32'h0};
        vt[5]  = '{1'b1, 4'h0, 32'h2,        4'hF, 1'b1, 4'h4, 32'h0};
        vt[6]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 32'h0};
        vt[7]  = '{1'b1, 4'hC, 32'h3,        4'hF, 1'b1, 4'hC, 32'h0};
        vt[8]  = '{1'b1, 4'h8, 32'h2,        4'hF, 1'b0, 4'h8, 32'h0};
        vt[9]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h8, 32'h2};
        vt[10] = '{1'b1, 4'h0, 32'h1,        4'hE, 1'b1, 4'h4, 32'h0};
        vt[11] = '{1'b1, 4'h8, 32'h0,        4'hF, 1'b1, 4'h8, 32'h0};

        // Reset state
        #12;
        push("rst_step_pulse", 0); pop_check(32'(step_pulse));
        push("rst_heading", 0);    pop_check(32'(heading));
        push("rst_state", 0);      pop_check(32'(game_state));
        push("rst_irq", 0);        pop_check(32'(irq));
        push("rst_status", 0);     rd(4'h4, r); pop_check(r);
        step();
        rst = 1'b0;
        step();

        // Register vectors in IDLE
        for (int i = 0; i < 12; i++) begin
            push($sformatf("vec%0d", i), vt[i].exp);
            if (vt[i].do_wr) begin
                wr_en = 1'b1; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_strb = vt[i].strb;
                step();
                wr_en = 1'b0;
            end
            rd_en = vt[i].re; rd_addr = vt[i].ra;
            #1;
            pop_check(rd_data);
            rd_en = 1'b0;
        end

        // Pacing and interrupt
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h1);
        push("pace1", 10); measure(n); pop_check(32'(n));
        push("irq_step", 1); pop_check(32'(irq));
        push("pace2", 10); measure(n); pop_check(32'(n));
        push("status_2steps", 32'h00020001); rd(4'h4, r); pop_check(r);
        wr(4'hC, 32'h1);
        push("irq_w1c", 0); pop_check(32'(irq));

        // Turns: left then right in one interval
        pulse(0);
        pulse(1);
        push("turn_lr_dist", 7); measure(n); pop_check(32'(n));
        push("turn_lr_heading", 3); pop_check(32'(heading));

        // Simultaneous left+right ignored
        turn_left = 1'b1; turn_right = 1'b1;
        step();
        turn_left = 1'b0; turn_right = 1'b0;
        push("turn_both_dist", 9); measure(n); pop_check(32'(n));
        push("turn_both_heading", 3); pop_check(32'(heading));

        // Turn coincident with a tick applies at the following tick
        repeat (9) step();
        push("tick_with_turn_pulse", 1);
        push("tick_with_turn_heading", 3);
        pulse(1);
        pop_check(32'(step_pulse));
        pop_check(32'(heading));
        push("late_turn_dist", 10); measure(n); pop_check(32'(n));
        push("late_turn_heading", 0); pop_check(32'(heading));
        pulse(0);
        push("left_wrap_dist", 9); measure(n); pop_check(32'(n));
        push("left_wrap_heading", 3); pop_check(32'(heading));
        push("irq_before_rst", 1); pop_check(32'(irq));

        // Asynchronous reset mid-RUN
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        push("arst_step_pulse", 0); pop_check(32'(step_pulse));
        push("arst_heading", 0);    pop_check(32'(heading));
        push("arst_state", 0);      pop_check(32'(game_state));
        push("arst_irq", 0);        pop_check(32'(irq));
        push("arst_status", 0);     rd(4'h4, r); pop_check(r);
        step();
        rst = 1'b0;
        step();

        // Speed-up: periods 7, 4, 4; levels 1, 2, 2
        wr(4'h0, 32'h1);
        turn_right = 1'b1;
        pulse(2);
        push("speed1_status", 32'h00000011); rd(4'h4, r); pop_check(r);
        pulse(2);
        push("speed2_status", 32'h00000021); rd(4'h4, r); pop_check(r);
        pulse(2);
        push("speed3_status", 32'h00000021); rd(4'h4, r); pop_check(r);
        push("speed_first_tick", 7); measure(n); pop_check(32'(n));
        push("speed_heading", 1); pop_check(32'(heading));
        push("speed_spacing_a", 4); measure(n); pop_check(32'(n));
        push("speed_spacing_b", 4); measure(n); pop_check(32'(n));
        push("speed_status_end", 32'h00030025); rd(4'h4, r); pop_check(r);

        // restart_req returns everything to restart values
        pulse(3);
        push("restart_status", 0); rd(4'h4, r); pop_check(r);
        push("restart_heading", 0); pop_check(32'(heading));
        push("restart_ifr_kept", 1); rd(4'hC, r); pop_check(r);
        pulse(4);
        push("idle_error_ignored", 0); pop_check(32'(game_state));

        // Pause: entered at cnt=5, 7 cycles in PAUSE
        wr(4'h0, 32'h1);
        repeat (4) step();
        wr(4'h0, 32'h2);
        push("pause_state", 2); pop_check(32'(game_state));
        repeat (6) step();
        wr(4'h0, 32'h4);
        push("resume_state", 1); pop_check(32'(game_state));
        push("pause_delay", 5); measure(n); pop_check(32'(n));

        // error_in coincident with a tick
        wr(4'hC, 32'h3);
        wr(4'h8, 32'h2);
        repeat (7) step();
        pulse(4);
        push("over_state", 3);        pop_check(32'(game_state));
        push("over_no_pulse", 0);     pop_check(32'(step_pulse));
        push("over_ifr", 2);          rd(4'hC, r); pop_check(r);
        push("over_irq", 1);          pop_check(32'(irq));
        push("over_status", 32'h00010003); rd(4'h4, r); pop_check(r);
        wr(4'h0, 32'h4);
        push("over_resume_ignored", 3); pop_check(32'(game_state));
        pulse(3);
        push("over_restart_state", 0); pop_check(32'(game_state));
        push("over_restart_ifr", 2);   rd(4'hC, r); pop_check(r);

        // W1C coincident with a STEP set: set wins
        wr(4'h0, 32'h1);
        repeat (9) step();
        wr(4'hC, 32'h1);
        push("w1c_vs_set_pulse", 1); pop_check(32'(step_pulse));
        push("w1c_vs_set_ifr", 3);   rd(4'hC, r); pop_check(r);

        while (sb_name.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_leftover: %s never compared", sb_name.pop_front());
            void'(sb_exp.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_step_ctrl.md
# game_step_ctrl

Memory-mapped game sequencer that turns the button peripheral's decoded events (turn, speed-up, game reset, error) into a paced game-step schedule. It owns the run/pause/over state machine, the current heading, the speed level and the step period, and emits one step pulse per game tick. It sits on the same register bus as the button peripheral, beside it, and raises its own interrupt.

## Interface
- `BASE_PERIOD`, default 10000000: step period in clocks after restart (100 ms at 100 MHz).
- `PERIOD_STEP`, default 1000000: period decrement per accepted speed-up.
- `MIN_PERIOD`, default 2000000: period floor, ≥2. All periods fit 24 bits.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_addr` in 4: write address; `wr_addr[3:2]` selects the register.
- `wr_en` in 1: write enable.
- `wr_data` in 32: write data.
- `wr_strb` in 4: byte strobes. Writes take effect only when `wr_strb == 4'b1111`.
- `rd_addr` in 4: read address.
- `rd_en` in 1: read enable.
- `rd_data` out 32: combinational read data. It is 0 when no register is selected.
- `turn_left` in 1: single-cycle turn-left request.
- `turn_right` in 1: single-cycle turn-right request.
- `speedup_req` in 1: single-cycle speed-up request.
- `restart_req` in 1: single-cycle game-reset request.
- `error_in` in 1: single-cycle game-over event.
- `step_pulse` out 1: registered; high for 1 cycle per game step.
- `heading` out 2: registered. Encoding: 0 up, 1 right, 2 down, 3 left.
- `game_state` out 2: registered. Encoding: 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
- `irq` out 1: equals `|(ier & ifr)`.

## Operation
- **Registers:**
  - 0x00 CMD (W, reads 0). Write-1 pulses: bit0 START, bit1 PAUSE, bit2 RESUME, bit3 RESTART.
  - 0x04 STATUS (RO). Fields: [1:0] state, [3:2] heading, [7:4] level, [31:16] step_cnt; other bits 0.
  - 0x08 IER (R/W, bits [1:0]).
  - 0x0C IFR (R/W1C). bit0 STEP, bit1 OVER.
- **FSM:**
  - IDLE→RUN on START. On this transition, load `cnt = period-1`.
  - RUN→PAUSE on PAUSE. PAUSE→RUN on RESUME; `cnt` is held, not reloaded.
  - RUN/PAUSE→OVER on `error_in`; set IFR.OVER.
  - Any state→IDLE on RESTART (CMD bit3 or `restart_req`). This sets heading=0, level=0, period=`BASE_PERIOD`, step_cnt=0 and `cnt=0`. IER and IFR are untouched.
  - Commands not valid in the current state are ignored.
  - `error_in` in IDLE or OVER is ignored.
- **Priority, per cycle:** RESTART > `error_in` > CMD START/PAUSE/RESUME.
- **Step tick** = state RUN, `cnt==0`, no RESTART and no `error_in` that cycle. On a tick:
  - reload `cnt = period-1`;
  - apply the pending turn to heading;
  - step_cnt += 1 (16-bit, wraps 0xFFFF→0);
  - set IFR.STEP;
  - set `step_pulse` register to 1.
- Outside a tick, `cnt` decrements in RUN and holds in every other state.
- **Turns:**
  - A single pending-turn slot is captured in RUN or PAUSE. The first request since the last tick wins; later requests are ignored until the tick.
  - `turn_left` and `turn_right` in the same cycle are both ignored.
  - Left: heading−1 mod 4. Right: heading+1 mod 4.
  - The slot is cleared on tick and on RESTART.
  - A turn request arriving in the same cycle as a tick applies to the next tick.
- **Speed-up:**
  - Accepted in RUN or PAUSE only.
  - `period = max(period−PERIOD_STEP, MIN_PERIOD)`.
  - level += 1, saturating at 15, only when period actually decreased.
  - The new period takes effect at the next reload; `cnt` is not modified.
- **IFR:** a set has priority over a W1C clear in the same cycle.

## Timing
- **Reset values:**
  - `rd_data` = 0 when idle; `step_pulse` 0; `heading` 0; `game_state` 0; `irq` 0.
  - IER 0, IFR 0, period `BASE_PERIOD`, level 0, `cnt` 0, step_cnt 0, pending-turn slot empty.
- Register writes take effect at the clock edge where `wr_en` is sampled. Reads are combinational in the same cycle.
- START sampled at edge t gives step ticks at edges t+P, t+2P, … (P = period). `step_pulse` is high during the cycle after each tick edge, together with the updated `heading`.
- PAUSE for N cycles delays every subsequent tick by N cycles.
- `game_state` and IFR.OVER update on the edge that samples `error_in`. `irq` follows combinationally.
- `rst` asserted mid-count clears everything immediately, without waiting for a clock edge.

## Test plan
- **Reset:** assert `rst` asynchronously mid-RUN → all outputs 0 at once; STATUS reads 0x00000000.
- **Pacing and interrupt:** BASE_PERIOD=10, START at edge t → `step_pulse` after edges t+10 and t+20; STATUS[31:16]=2. With IER=1, `irq`=1; W1C of 0x1 → `irq`=0.
- **Speed-up:** PERIOD_STEP=3, MIN_PERIOD=4; 3× `speedup_req` → period 7, 4, 4; level 1, 2, 2; tick spacing becomes 4 after the next reload.
- **Turns:**
  - `turn_left` then `turn_right` within one interval → heading 0→3 at the tick; right is ignored.
  - Simultaneous left+right → heading unchanged.
- **Pause:** PAUSE at `cnt`=5, hold 7 cycles, RESUME → next tick exactly 7 cycles late; no reload.
- **Game over and restart:**
  - `error_in` coincident with a tick → OVER, no `step_pulse`, IFR=0b10.
  - IFR W1C coincident with a set → the bit stays 1.
  - `restart_req` → IDLE, heading 0, level 0, period 10.
